// File: rtl/simplerisc_pkg.sv
// Shared encodings for the SimpleRISC operand-fetch/decode stage:
// opcodes, one-hot ALU bit positions, control-flag positions and immediate modifiers.
package simplerisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_CMP = 2;
    localparam int ALU_MUL = 3;
    localparam int ALU_DIV = 4;
    localparam int ALU_MOD = 5;
    localparam int ALU_LSL = 6;
    localparam int ALU_LSR = 7;
    localparam int ALU_ASR = 8;
    localparam int ALU_OR  = 9;
    localparam int ALU_AND = 10;
    localparam int ALU_NOT = 11;
    localparam int ALU_MOV = 12;

    localparam int CTRL_ST      = 0;
    localparam int CTRL_LD      = 1;
    localparam int CTRL_WB      = 2;
    localparam int CTRL_BEQ     = 3;
    localparam int CTRL_BGT     = 4;
    localparam int CTRL_UBRANCH = 5;
    localparam int CTRL_RET     = 6;
    localparam int CTRL_CALL    = 7;

    localparam logic [1:0] MOD_SEXT = 2'b00;
    localparam logic [1:0] MOD_ZEXT = 2'b01;
    localparam logic [1:0] MOD_HIGH = 2'b10;

endpackage

// File: rtl/simplerisc_ctrl_decode.sv
// Combinational decode of opcode/immediate fields into the ALU control word,
// control flags, isImmediate and the extended immediate.
module simplerisc_ctrl_decode
    import simplerisc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSIG  = 13
) (
    input  logic [4:0]       opcode,
    input  logic             imm_flag,
    input  logic [1:0]       modifier,
    input  logic [15:0]      imm,
    output logic [NSIG-1:0]  alu_signals,
    output logic [7:0]       ctrl,
    output logic             is_immediate,
    output logic [WIDTH-1:0] immx,
    output logic             illegal
);

    logic alu_op;
    logic mem_op;

    assign alu_op = (opcode <= OP_ASR);
    assign mem_op = (opcode == OP_LD) || (opcode == OP_ST);

    always_comb begin
        alu_signals = '0;
        illegal     = 1'b0;
        case (opcode)
            OP_ADD:  alu_signals[ALU_ADD] = 1'b1;
            OP_SUB:  alu_signals[ALU_SUB] = 1'b1;
            OP_MUL:  alu_signals[ALU_MUL] = 1'b1;
            OP_DIV:  alu_signals[ALU_DIV] = 1'b1;
            OP_MOD:  alu_signals[ALU_MOD] = 1'b1;
            OP_CMP:  alu_signals[ALU_CMP] = 1'b1;
            OP_AND:  alu_signals[ALU_AND] = 1'b1;
            OP_OR:   alu_signals[ALU_OR]  = 1'b1;
            OP_NOT:  alu_signals[ALU_NOT] = 1'b1;
            OP_MOV:  alu_signals[ALU_MOV] = 1'b1;
            OP_LSL:  alu_signals[ALU_LSL] = 1'b1;
            OP_LSR:  alu_signals[ALU_LSR] = 1'b1;
            OP_ASR:  alu_signals[ALU_ASR] = 1'b1;
            // address generation for memory ops reuses the adder
            OP_LD, OP_ST: alu_signals[ALU_ADD] = 1'b1;
            OP_NOP, OP_BEQ, OP_BGT, OP_B, OP_CALL, OP_RET: alu_signals = '0;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ctrl               = '0;
        ctrl[CTRL_ST]      = (opcode == OP_ST);
        ctrl[CTRL_LD]      = (opcode == OP_LD);
        ctrl[CTRL_WB]      = (alu_op && (opcode != OP_CMP)) || (opcode == OP_LD) || (opcode == OP_CALL);
        ctrl[CTRL_BEQ]     = (opcode == OP_BEQ);
        ctrl[CTRL_BGT]     = (opcode == OP_BGT);
        ctrl[CTRL_UBRANCH] = (opcode == OP_B) || (opcode == OP_CALL) || (opcode == OP_RET);
        ctrl[CTRL_RET]     = (opcode == OP_RET);
        ctrl[CTRL_CALL]    = (opcode == OP_CALL);
    end

    assign is_immediate = (alu_op || mem_op) && imm_flag;

    always_comb begin
        case (modifier)
            MOD_ZEXT: immx = WIDTH'(imm);
            MOD_HIGH: immx = WIDTH'({imm, 16'h0000});
            default:  immx = {{(WIDTH-16){imm[15]}}, imm};
        endcase
    end

endmodule

// File: rtl/simplerisc_of_decode_latch.sv
// OF stage: decodes the fetched instruction and holds the result in the OF/EX
// latch with valid/ready backpressure and branch-flush handling.
module simplerisc_of_decode_latch
    import simplerisc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NSIG    = 13,
    parameter int RET_REG = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] rf_a,
    input  logic [WIDTH-1:0] rf_b,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] immx,
    output logic             isImmediate,
    output logic [NSIG-1:0]  aluSignals,
    output logic [7:0]       ctrl,
    output logic [3:0]       rd,
    output logic [WIDTH-1:0] branchTarget,
    output logic [WIDTH-1:0] pc_out,
    output logic             illegal
);

    logic [NSIG-1:0]  dec_alu;
    logic [7:0]       dec_ctrl;
    logic             dec_isimm;
    logic [WIDTH-1:0] dec_immx;
    logic             dec_illegal;
    logic [3:0]       dec_rd;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_target;

    simplerisc_ctrl_decode #(
        .WIDTH (WIDTH),
        .NSIG  (NSIG)
    ) u_decode (
        .opcode       (instruction[31:27]),
        .imm_flag     (instruction[26]),
        .modifier     (instruction[17:16]),
        .imm          (instruction[15:0]),
        .alu_signals  (dec_alu),
        .ctrl         (dec_ctrl),
        .is_immediate (dec_isimm),
        .immx         (dec_immx),
        .illegal      (dec_illegal)
    );

    // call links into ra, so its destination is fixed regardless of the rd field
    assign dec_rd    = dec_ctrl[CTRL_CALL] ? 4'(RET_REG) : instruction[25:22];
    assign br_off    = {{(WIDTH-27){instruction[26]}}, instruction[26:0]};
    assign br_target = pc + (br_off << 2);

    logic             valid_q;
    logic [NSIG-1:0]  alu_q;
    logic [7:0]       ctrl_q;
    logic             isimm_q;
    logic [WIDTH-1:0] immx_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [3:0]       rd_q;
    logic [WIDTH-1:0] bt_q;
    logic [WIDTH-1:0] pc_q;
    logic             ill_q;
    logic             take;

    assign in_ready = ex_ready | ~valid_q;
    assign take     = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            ctrl_q  <= '0;
            isimm_q <= 1'b0;
            immx_q  <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            rd_q    <= '0;
            bt_q    <= '0;
            pc_q    <= '0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (take) begin
            valid_q <= 1'b1;
            alu_q   <= dec_alu;
            ctrl_q  <= dec_ctrl;
            isimm_q <= dec_isimm;
            immx_q  <= dec_immx;
            op1_q   <= rf_a;
            op2_q   <= rf_b;
            rd_q    <= dec_rd;
            bt_q    <= br_target;
            pc_q    <= pc;
            ill_q   <= dec_illegal;
        end else if (ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    // a bubble must never carry live control into EX even if stale data remains
    assign out_valid    = valid_q;
    assign aluSignals   = valid_q ? alu_q  : '0;
    assign ctrl         = valid_q ? ctrl_q : '0;
    assign illegal      = valid_q & ill_q;
    assign isImmediate  = isimm_q;
    assign immx         = immx_q;
    assign op1          = op1_q;
    assign op2          = op2_q;
    assign rd           = rd_q;
    assign branchTarget = bt_q;
    assign pc_out       = pc_q;

endmodule

// File: tb/tb_simplerisc_of_decode_latch.sv
// Scoreboard bench for the OF/EX decode latch: stimulus pushes expected results,
// a monitor pops and compares whenever EX consumes a valid latch entry.
module tb_simplerisc_of_decode_latch;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic        ex_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] immx;
    logic        isImmediate;
    logic [12:0] aluSignals;
    logic [7:0]  ctrl;
    logic [3:0]  rd;
    logic [31:0] branchTarget;
    logic [31:0] pc_out;
    logic        illegal;

    simplerisc_of_decode_latch #(.WIDTH(32), .NSIG(13), .RET_REG(15)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .rf_a(rf_a), .rf_b(rf_b),
        .ex_ready(ex_ready), .flush(flush), .out_valid(out_valid),
        .op1(op1), .op2(op2), .immx(immx), .isImmediate(isImmediate),
        .aluSignals(aluSignals), .ctrl(ctrl), .rd(rd),
        .branchTarget(branchTarget), .pc_out(pc_out), .illegal(illegal)
    );

    typedef struct {
        logic [12:0] alu;
        logic [7:0]  ctl;
        logic        isimm;
        logic [31:0] imx;
        logic [3:0]  rdv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] bt;
        logic [31:0] pcv;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic i, input logic [3:0] rdf,
                                       input logic [3:0] rs1, input logic [1:0] md, input logic [15:0] imm);
        return {op, i, rdf, rs1, md, imm};
    endfunction

    function automatic logic [31:0] bt_of(input logic [31:0] p, input logic [31:0] ins);
        logic [31:0] off;
        off = {{5{ins[26]}}, ins[26:0]};
        return p + (off << 2);
    endfunction

    function automatic exp_t mkexp(input logic [12:0] alu, input logic [7:0] ctl, input logic isimm,
                                   input logic [31:0] imx, input logic [3:0] rdv, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] bt, input logic [31:0] pcv,
                                   input logic ill);
        exp_t e;
        e.alu = alu; e.ctl = ctl; e.isimm = isimm; e.imx = imx; e.rdv = rdv;
        e.a = a; e.b = b; e.bt = bt; e.pcv = pcv; e.ill = ill;
        return e;
    endfunction

    // Present one instruction until accepted, record its expected latch image.
    task automatic issue(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        bit got;
        got = 0;
        instruction = ins; pc = p; rf_a = a; rf_b = b; in_valid = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = in_ready;
        end
        if (!got) check("issue_timeout", 32'(in_ready), 32'd1);
        else sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle2;
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) begin
                check("bubble_alu", 32'(aluSignals), 32'd0);
                check("bubble_ctrl", 32'(ctrl), 32'd0);
            end else if (flush) begin
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (ex_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    me = sb.pop_front();
                    check("aluSignals", 32'(aluSignals), 32'(me.alu));
                    check("ctrl", 32'(ctrl), 32'(me.ctl));
                    check("isImmediate", 32'(isImmediate), 32'(me.isimm));
                    check("immx", immx, me.imx);
                    check("rd", 32'(rd), 32'(me.rdv));
                    check("op1", op1, me.a);
                    check("op2", op2, me.b);
                    check("branchTarget", branchTarget, me.bt);
                    check("pc_out", pc_out, me.pcv);
                    check("illegal", 32'(illegal), 32'(me.ill));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        reset = 1'b1; in_valid = 1'b0; instruction = '0; pc = '0; rf_a = '0; rf_b = '0;
        ex_ready = 1'b1; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu", 32'(aluSignals), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_immx", immx, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        idle2();

        // add r1,r2,#-5 with one-cycle latency
        ins = mk(5'd0, 1'b1, 4'd1, 4'd2, 2'b00, 16'hFFFB);
        issue(ins, 32'h100, 32'd10, 32'd7,
              mkexp(13'h0001, 8'h04, 1'b1, 32'hFFFF_FFFB, 4'd1, 32'd10, 32'd7, bt_of(32'h100, ins), 32'h100, 1'b0));
        check("latency_out_valid", 32'(out_valid), 32'd1);

        ins = mk(5'd7, 1'b1, 4'd3, 4'd4, 2'b01, 16'h1234);
        issue(ins, 32'h104, 32'd1, 32'd2,
              mkexp(13'h0200, 8'h04, 1'b1, 32'h0000_1234, 4'd3, 32'd1, 32'd2, bt_of(32'h104, ins), 32'h104, 1'b0));
        ins = mk(5'd7, 1'b1, 4'd3, 4'd4, 2'b10, 16'h1234);
        issue(ins, 32'h108, 32'd3, 32'd4,
              mkexp(13'h0200, 8'h04, 1'b1, 32'h1234_0000, 4'd3, 32'd3, 32'd4, bt_of(32'h108, ins), 32'h108, 1'b0));
        ins = mk(5'd1, 1'b1, 4'd5, 4'd0, 2'b00, 16'h8000);
        issue(ins, 32'h10C, 32'd5, 32'd6,
              mkexp(13'h0002, 8'h04, 1'b1, 32'hFFFF_8000, 4'd5, 32'd5, 32'd6, bt_of(32'h10C, ins), 32'h10C, 1'b0));
        ins = mk(5'd9, 1'b1, 4'd6, 4'd0, 2'b11, 16'h8001);
        issue(ins, 32'h110, 32'd0, 32'd9,
              mkexp(13'h1000, 8'h04, 1'b1, 32'hFFFF_8001, 4'd6, 32'd0, 32'd9, bt_of(32'h110, ins), 32'h110, 1'b0));

        // beq offset -2 at 0x40 -> 0x38
        issue({5'd16, 27'h7FF_FFFE}, 32'h40, 32'd1, 32'd2,
              mkexp(13'h0000, 8'h08, 1'b0, 32'hFFFF_FFFE, 4'd15, 32'd1, 32'd2, 32'h38, 32'h40, 1'b0));
        issue({5'd19, 27'd4}, 32'h200, 32'd0, 32'd0,
              mkexp(13'h0000, 8'hA4, 1'b0, 32'h4, 4'd15, 32'd0, 32'd0, 32'h210, 32'h200, 1'b0));
        issue(mk(5'd20, 1'b0, 4'd0, 4'd0, 2'b00, 16'h0), 32'h300, 32'h1234, 32'd0,
              mkexp(13'h0000, 8'h60, 1'b0, 32'h0, 4'd0, 32'h1234, 32'd0, 32'h300, 32'h300, 1'b0));
        issue({5'd17, 27'd1}, 32'h400, 32'd0, 32'd0,
              mkexp(13'h0000, 8'h10, 1'b0, 32'h1, 4'd0, 32'd0, 32'd0, 32'h404, 32'h400, 1'b0));
        ins = mk(5'd14, 1'b1, 4'd2, 4'd3, 2'b00, 16'h0010);
        issue(ins, 32'h500, 32'd100, 32'd0,
              mkexp(13'h0001, 8'h06, 1'b1, 32'h10, 4'd2, 32'd100, 32'd0, bt_of(32'h500, ins), 32'h500, 1'b0));
        ins = mk(5'd15, 1'b0, 4'd4, 4'd3, 2'b00, 16'h0020);
        issue(ins, 32'h504, 32'd100, 32'd77,
              mkexp(13'h0001, 8'h01, 1'b0, 32'h20, 4'd4, 32'd100, 32'd77, bt_of(32'h504, ins), 32'h504, 1'b0));
        ins = mk(5'd13, 1'b1, 4'd0, 4'd0, 2'b00, 16'h0);
        issue(ins, 32'h508, 32'd0, 32'd0,
              mkexp(13'h0000, 8'h00, 1'b0, 32'h0, 4'd0, 32'd0, 32'd0, bt_of(32'h508, ins), 32'h508, 1'b0));
        ins = mk(5'd25, 1'b1, 4'd7, 4'd0, 2'b01, 16'hABCD);
        issue(ins, 32'h600, 32'd1, 32'd2,
              mkexp(13'h0000, 8'h00, 1'b0, 32'h0000_ABCD, 4'd7, 32'd1, 32'd2, bt_of(32'h600, ins), 32'h600, 1'b1));
        ins = mk(5'd21, 1'b0, 4'd0, 4'd0, 2'b00, 16'h0);
        issue(ins, 32'h604, 32'd0, 32'd0,
              mkexp(13'h0000, 8'h00, 1'b0, 32'h0, 4'd0, 32'd0, 32'd0, bt_of(32'h604, ins), 32'h604, 1'b1));
        idle2();

        // cmp held under a 3-cycle stall with a waiting instruction
        ex_ready = 1'b0;
        ins = mk(5'd5, 1'b0, 4'd0, 4'd1, 2'b00, 16'h0);
        issue(ins, 32'h700, 32'h55, 32'h66,
              mkexp(13'h0004, 8'h00, 1'b0, 32'h0, 4'd0, 32'h55, 32'h66, bt_of(32'h700, ins), 32'h700, 1'b0));
        instruction = mk(5'd2, 1'b0, 4'd8, 4'd1, 2'b00, 16'h0);
        pc = 32'h704; rf_a = 32'd3; rf_b = 32'd4; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_alu", 32'(aluSignals), 32'h0004);
            check("stall_op1", op1, 32'h55);
            check("stall_op2", op2, 32'h66);
            check("stall_pc", pc_out, 32'h700);
        end
        @(posedge clk); #1;
        ex_ready = 1'b1;
        ins = mk(5'd2, 1'b0, 4'd8, 4'd1, 2'b00, 16'h0);
        issue(ins, 32'h704, 32'd3, 32'd4,
              mkexp(13'h0008, 8'h04, 1'b0, 32'h0, 4'd8, 32'd3, 32'd4, bt_of(32'h704, ins), 32'h704, 1'b0));
        check("release_load", 32'(aluSignals), 32'h0008);
        idle2();

        // flush while stalled with a pending instruction
        ex_ready = 1'b0;
        ins = mk(5'd11, 1'b0, 4'd9, 4'd1, 2'b00, 16'h0);
        issue(ins, 32'h800, 32'd8, 32'd1,
              mkexp(13'h0080, 8'h04, 1'b0, 32'h0, 4'd9, 32'd8, 32'd1, bt_of(32'h800, ins), 32'h800, 1'b0));
        instruction = mk(5'd0, 1'b0, 4'd3, 4'd1, 2'b00, 16'h0);
        pc = 32'h804; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_alu", 32'(aluSignals), 32'd0);
        check("flush_ctrl", 32'(ctrl), 32'd0);
        ex_ready = 1'b1;
        @(posedge clk); #1;
        check("flush_dropped", 32'(out_valid), 32'd0);

        // flush beats an otherwise accepted transfer into an empty latch
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_empty_drop", 32'(out_valid), 32'd0);

        // async reset in the middle of a stall
        ex_ready = 1'b0;
        ins = mk(5'd6, 1'b1, 4'd2, 4'd1, 2'b01, 16'h00FF);
        issue(ins, 32'h900, 32'd11, 32'd12,
              mkexp(13'h0400, 8'h04, 1'b1, 32'hFF, 4'd2, 32'd11, 32'd12, bt_of(32'h900, ins), 32'h900, 1'b0));
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_alu", 32'(aluSignals), 32'd0);
        check("async_rst_ctrl", 32'(ctrl), 32'd0);
        check("async_rst_immx", immx, 32'd0);
        check("async_rst_op1", op1, 32'd0);
        check("async_rst_rd", 32'(rd), 32'd0);
        check("async_rst_pc", pc_out, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        ex_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
